// File: rtl/sc_random_pkg.sv
// -----------------------------------------------------------------------------
// sc_random_pkg
// Shared definitions for the 8-bit pseudo-random link: seed value, feedback
// taps, the forbidden nibble, checker state encoding and the step function.
// The generator imports the same random_step() so both ends of the link
// always agree on the sequence.
// -----------------------------------------------------------------------------
package sc_random_pkg;

  localparam logic [7:0] RANDOM_SEED      = 8'h01;
  localparam int         TAP_HI           = 7;
  localparam int         TAP_LO           = 4;
  localparam logic [3:0] NIBBLE_FORBIDDEN = 4'hF;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rand_state_t;

  // One step of the sequence: shift left with XOR feedback, and fall back to
  // the seed whenever either nibble would become the forbidden value.
  function automatic logic [7:0] random_step(input logic [7:0] r);
    logic [7:0] n;
    n = {r[6:0], r[TAP_HI] ^ r[TAP_LO]};
    if ((n[7:4] == NIBBLE_FORBIDDEN) || (n[3:0] == NIBBLE_FORBIDDEN)) begin
      random_step = RANDOM_SEED;
    end else begin
      random_step = n;
    end
  endfunction

  // A value the generator can actually emit: non-zero, no forbidden nibble.
  function automatic logic is_valid_seed(input logic [7:0] v);
    is_valid_seed = (v != 8'h00) &&
                    (v[7:4] != NIBBLE_FORBIDDEN) &&
                    (v[3:0] != NIBBLE_FORBIDDEN);
  endfunction

endpackage

// File: rtl/sc_random_step.sv
// -----------------------------------------------------------------------------
// sc_random_step
// Purely combinational instance of the sequence step function.
// Ports:
//   cur  - current sequence value
//   next - value that follows cur in the sequence
// -----------------------------------------------------------------------------
module sc_random_step
  import sc_random_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] next
);

  // Evaluate the shared step function.
  always_comb begin
    next = random_step(cur);
  end

endmodule

// File: rtl/sc_random_checker.sv
// -----------------------------------------------------------------------------
// sc_random_checker
// Receive-side checker for the 8-bit LFSR byte stream. Hunts for a valid seed,
// confirms LOCK_COUNT consecutive in-sequence samples, then free-runs its own
// copy of the sequence and flags every received byte that differs from it.
// LOSS_COUNT consecutive misses drop it back to hunting.
// Ports:
//   SC_RANDCHK_CLOCK_50          - clock, rising edge
//   SC_RANDCHK_RESET_InLow       - synchronous active-low reset
//   SC_RANDCHK_data_InBUS        - received byte
//   SC_RANDCHK_valid_InHigh      - received byte is valid this cycle
//   SC_RANDCHK_clear_InHigh      - clear the error counter
//   SC_RANDCHK_locked_OutHigh    - locked to the sequence
//   SC_RANDCHK_mismatch_OutHigh  - one-cycle pulse on a locked-state miss
//   SC_RANDCHK_errcount_OutBUS   - saturating miss counter
//   SC_RANDCHK_expected_OutBUS   - expected value of the next sample
// Only DATAWIDTH = 8 is meaningful: the taps and nibble rule are fixed.
// -----------------------------------------------------------------------------
module sc_random_checker
  import sc_random_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int LOCK_COUNT   = 4,
  parameter int LOSS_COUNT   = 3,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    SC_RANDCHK_CLOCK_50,
  input  logic                    SC_RANDCHK_RESET_InLow,
  input  logic [DATAWIDTH-1:0]    SC_RANDCHK_data_InBUS,
  input  logic                    SC_RANDCHK_valid_InHigh,
  input  logic                    SC_RANDCHK_clear_InHigh,
  output logic                    SC_RANDCHK_locked_OutHigh,
  output logic                    SC_RANDCHK_mismatch_OutHigh,
  output logic [ERRCNT_WIDTH-1:0] SC_RANDCHK_errcount_OutBUS,
  output logic [DATAWIDTH-1:0]    SC_RANDCHK_expected_OutBUS
);

  localparam int HUNT_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  localparam logic [HUNT_W-1:0] HUNT_LIMIT = HUNT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_COUNT);

  rand_state_t            state;
  logic [HUNT_W-1:0]      hunt_cnt;
  logic [MISS_W-1:0]      miss_cnt;
  logic [7:0]             expected;
  logic                   locked;
  logic                   mismatch;
  logic [ERRCNT_WIDTH-1:0] errcount;

  logic [7:0]        sample;
  logic              sample_match;
  logic              sample_seed;
  logic              use_sample;
  logic [7:0]        step_in;
  logic [7:0]        step_out;
  logic [HUNT_W-1:0] hunt_inc;
  logic [MISS_W-1:0] miss_inc;
  logic              err_full;

  assign sample = SC_RANDCHK_data_InBUS[7:0];

  // Decode the sample and pick what feeds the single step instance: while
  // hunting, a fresh seed or a reseed steps from the sample; every other case
  // (in-sequence hunt sample, any locked sample) steps from expected.
  always_comb begin
    sample_match = (sample == expected);
    sample_seed  = is_valid_seed(sample);
    hunt_inc     = hunt_cnt + HUNT_W'(1);
    miss_inc     = miss_cnt + MISS_W'(1);
    err_full     = &errcount;
    if ((state == HUNT) && ((hunt_cnt == '0) || !sample_match)) begin
      use_sample = 1'b1;
    end else begin
      use_sample = 1'b0;
    end
    if (use_sample) begin
      step_in = sample;
    end else begin
      step_in = expected;
    end
  end

  sc_random_step u_step (
    .cur  (step_in),
    .next (step_out)
  );

  // Checker FSM with all outputs registered.
  always_ff @(posedge SC_RANDCHK_CLOCK_50) begin
    if (!SC_RANDCHK_RESET_InLow) begin
      state    <= HUNT;
      hunt_cnt <= '0;
      miss_cnt <= '0;
      expected <= RANDOM_SEED;
      locked   <= 1'b0;
      mismatch <= 1'b0;
      errcount <= '0;
    end else begin
      mismatch <= 1'b0;
      if (SC_RANDCHK_valid_InHigh) begin
        case (state)
          HUNT: begin
            if ((hunt_cnt != '0) && sample_match) begin
              expected <= step_out;
              hunt_cnt <= hunt_inc;
              if (hunt_inc == HUNT_LIMIT) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state    <= HUNT;
              end
            end else if (sample_seed) begin
              // First seed, or reseed after an out-of-sequence sample.
              expected <= step_out;
              hunt_cnt <= HUNT_W'(1);
              if (HUNT_LIMIT == HUNT_W'(1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state    <= HUNT;
              end
            end else begin
              hunt_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run: never resynchronise to the received data.
            expected <= step_out;
            if (sample_match) begin
              miss_cnt <= '0;
            end else begin
              mismatch <= 1'b1;
              if (!err_full) begin
                errcount <= errcount + ERRCNT_WIDTH'(1);
              end else begin
                errcount <= errcount;
              end
              miss_cnt <= miss_inc;
              if (miss_inc == MISS_LIMIT) begin
                state    <= HUNT;
                locked   <= 1'b0;
                hunt_cnt <= '0;
              end else begin
                state    <= LOCKED;
              end
            end
          end
          default: begin
            state    <= HUNT;
            locked   <= 1'b0;
            hunt_cnt <= '0;
          end
        endcase
      end
      // Clear wins over a same-cycle increment; the pulse above still fires.
      if (SC_RANDCHK_clear_InHigh) begin
        errcount <= '0;
      end
    end
  end

  assign SC_RANDCHK_locked_OutHigh   = locked;
  assign SC_RANDCHK_mismatch_OutHigh = mismatch;
  assign SC_RANDCHK_errcount_OutBUS  = errcount;
  assign SC_RANDCHK_expected_OutBUS  = {{(DATAWIDTH-8){1'b0}}, expected};

endmodule

// File: tb/tb_sc_random_checker.sv
// -----------------------------------------------------------------------------
// tb_sc_random_checker
// Directed scenarios plus a randomized stream against a behavioural model.
// A second instance with a 4-bit error counter shares all inputs so that
// counter saturation can be reached in a few dozen cycles.
// -----------------------------------------------------------------------------
module tb_sc_random_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        clear;
  logic        locked, mismatch;
  logic [15:0] errcount;
  logic [7:0]  expected;
  logic        locked_s, mismatch_s;
  logic [3:0]  errcount_s;
  logic [7:0]  expected_s;

  always #5 clk = ~clk;

  sc_random_checker dut (
    .SC_RANDCHK_CLOCK_50         (clk),
    .SC_RANDCHK_RESET_InLow      (rst_n),
    .SC_RANDCHK_data_InBUS       (data),
    .SC_RANDCHK_valid_InHigh     (valid),
    .SC_RANDCHK_clear_InHigh     (clear),
    .SC_RANDCHK_locked_OutHigh   (locked),
    .SC_RANDCHK_mismatch_OutHigh (mismatch),
    .SC_RANDCHK_errcount_OutBUS  (errcount),
    .SC_RANDCHK_expected_OutBUS  (expected)
  );

  sc_random_checker #(.ERRCNT_WIDTH(4)) dut_small (
    .SC_RANDCHK_CLOCK_50         (clk),
    .SC_RANDCHK_RESET_InLow      (rst_n),
    .SC_RANDCHK_data_InBUS       (data),
    .SC_RANDCHK_valid_InHigh     (valid),
    .SC_RANDCHK_clear_InHigh     (clear),
    .SC_RANDCHK_locked_OutHigh   (locked_s),
    .SC_RANDCHK_mismatch_OutHigh (mismatch_s),
    .SC_RANDCHK_errcount_OutBUS  (errcount_s),
    .SC_RANDCHK_expected_OutBUS  (expected_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit         m_locked;
  int         m_hunt, m_miss;
  logic [7:0] m_exp;
  bit         m_mis;
  int         m_err, m_err_small;

  function automatic logic [7:0] ref_step(input int r);
    int n;
    n = ((r * 2) % 256) + (((r / 128) ^ (r / 16)) % 2);
    if ((n / 16 == 15) || (n % 16 == 15)) return 8'h01;
    return 8'(n);
  endfunction

  function automatic bit ref_seed(input int v);
    return (v != 0) && (v / 16 != 15) && (v % 16 != 15);
  endfunction

  // Drive one clock of stimulus, advance the model, settle past the edge.
  task automatic cycle(input logic [7:0] d, input logic v, input logic c);
    data  = d;
    valid = v;
    clear = c;
    @(posedge clk);
    if (!rst_n) begin
      m_locked = 0; m_hunt = 0; m_miss = 0; m_exp = 8'h01;
      m_mis = 0; m_err = 0; m_err_small = 0;
    end else begin
      m_mis = 0;
      if (v) begin
        if (!m_locked) begin
          if (m_hunt == 0) begin
            if (ref_seed(d)) begin m_exp = ref_step(d); m_hunt = 1; end
          end else if (d == m_exp) begin
            m_exp = ref_step(m_exp);
            m_hunt++;
            if (m_hunt == LOCK) begin m_locked = 1; m_miss = 0; end
          end else if (ref_seed(d)) begin
            m_exp = ref_step(d); m_hunt = 1;
          end else begin
            m_hunt = 0;
          end
        end else begin
          if (d != m_exp) begin
            m_mis = 1;
            if (m_err < 65535) m_err++;
            if (m_err_small < 15) m_err_small++;
            m_miss++;
            if (m_miss == LOSS) begin m_locked = 0; m_hunt = 0; end
          end else begin
            m_miss = 0;
          end
          m_exp = ref_step(m_exp);
        end
      end
      if (c) begin m_err = 0; m_err_small = 0; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(8'h5A, 1'b1, 1'b0);
    cycle(8'h5A, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (locked !== 1'b0 || mismatch !== 1'b0 || errcount !== 16'h0000 || expected !== 8'h01) begin
      n_fail++;
      $display("FAIL reset: locked=%b mis=%b err=%h exp=%h, want 0 0 0000 01", locked, mismatch, errcount, expected);
    end
    n_tests++;
    if (errcount_s !== 4'h0 || locked_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_small: err=%h locked=%b, want 0 0", errcount_s, locked_s);
    end
  endtask

  task automatic test_lock();
    cycle(8'h01, 1'b1, 1'b0);
    n_tests++;
    if (locked !== 1'b0 || expected !== 8'h02) begin
      n_fail++;
      $display("FAIL lock_seed: locked=%b exp=%h, want 0 02", locked, expected);
    end
    cycle(8'hEE, 1'b0, 1'b0);
    n_tests++;
    if (locked !== 1'b0 || expected !== 8'h02 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_idle: locked=%b exp=%h mis=%b, want 0 02 0", locked, expected, mismatch);
    end
    cycle(8'h02, 1'b1, 1'b0);
    cycle(8'h33, 1'b0, 1'b0);
    cycle(8'h04, 1'b1, 1'b0);
    n_tests++;
    if (locked !== 1'b0 || expected !== 8'h08) begin
      n_fail++;
      $display("FAIL lock_third: locked=%b exp=%h, want 0 08", locked, expected);
    end
    cycle(8'h08, 1'b1, 1'b0);
    n_tests++;
    if (locked !== 1'b1 || expected !== 8'h10 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_done: locked=%b exp=%h mis=%b, want 1 10 0", locked, expected, mismatch);
    end
  endtask

  task automatic test_single_mismatch();
    cycle(8'h10, 1'b1, 1'b0);
    n_tests++;
    if (mismatch !== 1'b0 || expected !== 8'h21) begin
      n_fail++;
      $display("FAIL single_match: mis=%b exp=%h, want 0 21", mismatch, expected);
    end
    cycle(8'h55, 1'b1, 1'b0);
    n_tests++;
    if (mismatch !== 1'b1 || errcount !== 16'h0001 || locked !== 1'b1 || expected !== 8'h42) begin
      n_fail++;
      $display("FAIL single_miss: mis=%b err=%h locked=%b exp=%h, want 1 0001 1 42", mismatch, errcount, locked, expected);
    end
    cycle(8'h42, 1'b1, 1'b0);
    n_tests++;
    if (mismatch !== 1'b0 || errcount !== 16'h0001 || locked !== 1'b1 || expected !== 8'h84) begin
      n_fail++;
      $display("FAIL single_after: mis=%b err=%h locked=%b exp=%h, want 0 0001 1 84", mismatch, errcount, locked, expected);
    end
  endtask

  task automatic test_loss_relock();
    logic [7:0] bad [3];
    logic [7:0] good [4];
    bad  = '{8'hAA, 8'hBB, 8'hCC};
    good = '{8'h84, 8'h09, 8'h12, 8'h25};
    for (int i = 0; i < 3; i++) begin
      cycle(bad[i], 1'b1, 1'b0);
      n_tests++;
      if (mismatch !== 1'b1 || errcount !== 16'(2 + i) || locked !== (i < 2)) begin
        n_fail++;
        $display("FAIL loss_%0d: mis=%b err=%h locked=%b, want 1 %h %b", i, mismatch, errcount, locked, 16'(2 + i), (i < 2));
      end
    end
    for (int i = 0; i < 4; i++) cycle(good[i], 1'b1, 1'b0);
    n_tests++;
    if (locked !== 1'b1 || expected !== 8'h4A || errcount !== 16'h0004 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL relock: locked=%b exp=%h err=%h mis=%b, want 1 4a 0004 0", locked, expected, errcount, mismatch);
    end
  endtask

  task automatic test_reset_midstream();
    cycle(8'h4A, 1'b1, 1'b0);
    rst_n = 1'b0;
    cycle(8'h94, 1'b1, 1'b0);
    cycle(8'h29, 1'b1, 1'b1);
    rst_n = 1'b1;
    n_tests++;
    if (locked !== 1'b0 || mismatch !== 1'b0 || errcount !== 16'h0000 || expected !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_mid: locked=%b mis=%b err=%h exp=%h, want 0 0 0000 01", locked, mismatch, errcount, expected);
    end
  endtask

  task automatic test_invalid_seeds();
    logic [7:0] junk [3];
    logic [7:0] seq [4];
    junk = '{8'h00, 8'hF3, 8'h3F};
    seq  = '{8'h17, 8'h01, 8'h02, 8'h04};
    for (int i = 0; i < 3; i++) cycle(junk[i], 1'b1, 1'b0);
    n_tests++;
    if (locked !== 1'b0 || expected !== 8'h01 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_seed: locked=%b exp=%h mis=%b, want 0 01 0", locked, expected, mismatch);
    end
    cycle(seq[0], 1'b1, 1'b0);
    n_tests++;
    if (expected !== 8'h01 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_17: exp=%h locked=%b, want 01 0", expected, locked);
    end
    for (int i = 1; i < 4; i++) cycle(seq[i], 1'b1, 1'b0);
    n_tests++;
    if (locked !== 1'b1 || expected !== 8'h08) begin
      n_fail++;
      $display("FAIL seed_lock: locked=%b exp=%h, want 1 08", locked, expected);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    cycle(8'h01, 1'b1, 1'b0);
    cycle(8'h02, 1'b1, 1'b0);
    cycle(8'h04, 1'b1, 1'b0);
    cycle(8'h08, 1'b1, 1'b0);
    // Two misses then a hit keeps the lock while piling up errors.
    for (int r = 0; r < 10; r++) begin
      cycle(m_exp ^ 8'h5A, 1'b1, 1'b0);
      cycle(m_exp ^ 8'hC3, 1'b1, 1'b0);
      cycle(m_exp, 1'b1, 1'b0);
    end
    n_tests++;
    if (errcount_s !== 4'hF || errcount !== 16'd20 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_fill: err_small=%h err=%0d locked=%b, want f 20 1", errcount_s, errcount, locked);
    end
    cycle(m_exp ^ 8'h11, 1'b1, 1'b0);
    n_tests++;
    if (errcount_s !== 4'hF || mismatch_s !== 1'b1 || errcount !== 16'd21) begin
      n_fail++;
      $display("FAIL sat_hold: err_small=%h mis=%b err=%0d, want f 1 21", errcount_s, mismatch_s, errcount);
    end
    cycle(m_exp ^ 8'h22, 1'b1, 1'b1);
    n_tests++;
    if (errcount !== 16'h0000 || errcount_s !== 4'h0 || mismatch !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_beats: err=%h err_small=%h mis=%b locked=%b, want 0000 0 1 1", errcount, errcount_s, mismatch, locked);
    end
  endtask

  task automatic test_random();
    logic [7:0] gen;
    logic [7:0] d;
    logic       v, c;
    int         bad_cnt;
    bad_cnt = 0;
    do_reset();
    gen = 8'h01;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 9) == 0) d = 8'($urandom);
      else d = gen;
      if ($urandom_range(0, 150) == 0) gen = 8'($urandom_range(1, 14));
      rst_n = ($urandom_range(0, 250) != 0);
      cycle(d, v, c);
      if (v) gen = ref_step(gen);
      rst_n = 1'b1;
      n_tests++;
      if (locked !== m_locked || mismatch !== m_mis || expected !== m_exp ||
          errcount !== 16'(m_err) || errcount_s !== 4'(m_err_small)) begin
        n_fail++;
        bad_cnt++;
        if (bad_cnt <= 10)
          $display("FAIL random_%0d: locked=%b mis=%b exp=%h err=%h errs=%h, want %b %b %h %h %h",
                   i, locked, mismatch, expected, errcount, errcount_s,
                   m_locked, m_mis, m_exp, 16'(m_err), 4'(m_err_small));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data  = 8'h00;
    valid = 1'b0;
    clear = 1'b0;
    test_reset();
    test_lock();
    test_single_mismatch();
    test_loss_relock();
    test_reset_midstream();
    test_invalid_seeds();
    test_saturation_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
